// File: rtl/instr_fetch.sv
// Instruction fetch unit: two-state FETCH/HOLD engine feeding a 20-bit instruction register.
// Define PREFETCH_BUF_EN to add a one-entry prefetch buffer for one-instruction-per-cycle throughput.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [19:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [19:0]       ir,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [7:0]        imm8,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [0:0] {StFetch, StHold} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [19:0]       ir_q;
  logic              ir_valid_q;
  logic              xfer;
  logic              fetch_ack;

`ifdef PREFETCH_BUF_EN
  logic [19:0] pbuf_q;
  logic        pbuf_valid_q;

  // In HOLD keep requesting until the buffer slot is occupied.
  assign mem_req = (state_q == StFetch) | ~pbuf_valid_q;
`else
  assign mem_req = (state_q == StFetch);
`endif

  assign mem_addr  = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign opcode    = ir_q[19:16];
  assign rd        = ir_q[15:12];
  assign rs        = ir_q[11:8];
  assign imm8      = ir_q[7:0];
  assign xfer      = ir_valid_q & ir_ready;
  assign fetch_ack = mem_req & mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StFetch;
      pc_q         <= RESET_PC;
      ir_q         <= 20'h0;
      ir_valid_q   <= 1'b0;
`ifdef PREFETCH_BUF_EN
      pbuf_q       <= 20'h0;
      pbuf_valid_q <= 1'b0;
`endif
    end else if (redirect) begin
      // Redirect wins over everything; a same-cycle ack or transfer is dropped/consumed.
      state_q      <= StFetch;
      pc_q         <= redirect_pc;
      ir_valid_q   <= 1'b0;
`ifdef PREFETCH_BUF_EN
      pbuf_valid_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StFetch: begin
          if (fetch_ack) begin
            ir_q       <= mem_rdata;
            ir_valid_q <= 1'b1;
            pc_q       <= pc_q + ADDR_W'(1);
            state_q    <= StHold;
          end
        end
        StHold: begin
`ifdef PREFETCH_BUF_EN
          if (xfer) begin
            if (pbuf_valid_q) begin
              ir_q         <= pbuf_q;
              pbuf_valid_q <= 1'b0;
            end else if (fetch_ack) begin
              ir_q <= mem_rdata;
              pc_q <= pc_q + ADDR_W'(1);
            end else begin
              ir_valid_q <= 1'b0;
              state_q    <= StFetch;
            end
          end else if (fetch_ack) begin
            pbuf_q       <= mem_rdata;
            pbuf_valid_q <= 1'b1;
            pc_q         <= pc_q + ADDR_W'(1);
          end
`else
          if (xfer) begin
            ir_valid_q <= 1'b0;
            state_q    <= StFetch;
          end
`endif
        end
        default: state_q <= StFetch;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: the reference is a queue of fetched-but-unconsumed words.
module tb_instr_fetch;

  localparam int unsigned AW = 12;
`ifdef PREFETCH_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [19:0]   mem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          ir_valid;
  logic          ir_ready = 1'b0;
  logic [19:0]   ir;
  logic [3:0]    opcode, rd, rs;
  logic [7:0]    imm8;
  logic [AW-1:0] pc;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  // Model: words fetched but not yet handed to decode; front is what ir must show.
  logic [19:0]   q[$];
  logic [AW-1:0] m_pc;

  instr_fetch #(.ADDR_W(AW), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .opcode(opcode), .rd(rd), .rs(rs),
    .imm8(imm8), .pc(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_pc = 12'h000;
  endtask

  task automatic model_update();
    bit req, xf;
    if (!rst_n) begin
      model_reset();
    end else begin
      req = (q.size() < CAP);
      xf  = (q.size() > 0) && ir_ready;
      if (redirect) begin
        q.delete();
        m_pc = redirect_pc;
      end else begin
        if (xf) void'(q.pop_front());
        if (req && mem_ack) begin
          q.push_back(mem_rdata);
          m_pc = m_pc + 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("mem_req", 32'(mem_req), 32'(q.size() < CAP));
      chk("mem_addr", 32'(mem_addr), 32'(m_pc));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ir_valid", 32'(ir_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        chk("ir", 32'(ir), 32'(q[0]));
        chk("opcode", 32'(opcode), 32'(q[0][19:16]));
        chk("rd", 32'(rd), 32'(q[0][15:12]));
        chk("rs", 32'(rs), 32'(q[0][11:8]));
        chk("imm8", 32'(imm8), 32'(q[0][7:0]));
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) step();
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_ir", 32'(ir), 32'h0);
    chk("rst_ir_valid", 32'(ir_valid), 32'h0);
    chk("rst_mem_req", 32'(mem_req), 32'h1);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    // First fetch right after reset release.
    mem_ack = 1'b1; mem_rdata = 20'hA3C5F;
    step();
    chk("first_valid", 32'(ir_valid), 32'h1);
    chk("first_opcode", 32'(opcode), 32'hA);
    chk("first_rd", 32'(rd), 32'h3);
    chk("first_rs", 32'(rs), 32'hC);
    chk("first_imm8", 32'(imm8), 32'h5F);
    chk("first_pc", 32'(pc), 32'h1);

    // Decode stalls: ir and pc hold.
    mem_ack = 1'b0; mem_rdata = 20'h77777;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_ir", 32'(ir), 32'hA3C5F);
      chk("stall_pc", 32'(pc), 32'h1);
`ifdef PREFETCH_BUF_EN
      chk("stall_req", 32'(mem_req), 32'h1);
`else
      chk("stall_req", 32'(mem_req), 32'h0);
`endif
    end
    ir_ready = 1'b1;
    step();
    chk("drain_valid", 32'(ir_valid), 32'h0);
    ir_ready = 1'b0;

    // Memory wait states: request and address held.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wait_req", 32'(mem_req), 32'h1);
      chk("wait_addr", 32'(mem_addr), 32'h1);
      chk("wait_valid", 32'(ir_valid), 32'h0);
    end
    mem_ack = 1'b1; mem_rdata = 20'h12345;
    step();
    chk("late_ir", 32'(ir), 32'h12345);
    chk("late_pc", 32'(pc), 32'h2);
    mem_ack = 1'b0; ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;

    // Redirect coinciding with an ack drops the data.
    redirect = 1'b1; redirect_pc = 12'h040; mem_ack = 1'b1; mem_rdata = 20'hFFFFF;
    step();
    chk("redir_addr", 32'(mem_addr), 32'h040);
    chk("redir_valid", 32'(ir_valid), 32'h0);

    // Fetch at the top address wraps pc to zero.
    redirect_pc = 12'hFFF; mem_ack = 1'b0;
    step();
    redirect = 1'b0; mem_ack = 1'b1; mem_rdata = 20'h0BEEF;
    step();
    chk("wrap_pc", 32'(pc), 32'h000);
    chk("wrap_ir", 32'(ir), 32'h0BEEF);
    mem_ack = 1'b0; ir_ready = 1'b1;
    step();

`ifdef PREFETCH_BUF_EN
    // Back-to-back: one instruction per cycle.
    mem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_rdata = 20'h10000 + 20'(i);
      step();
      chk("stream_valid", 32'(ir_valid), 32'h1);
      chk("stream_ir", 32'(ir), 32'h10000 + 32'(i));
    end
`endif
    mem_ack = 1'b0; ir_ready = 1'b0;

    // Random traffic, with occasional redirects and asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      mem_ack     = ($urandom_range(0, 9) < 6);
      ir_ready    = ($urandom_range(0, 9) < 6);
      mem_rdata   = 20'($urandom);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ? 12'hFFE : 12'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_pc", 32'(pc), 32'h0);
        chk("async_rst_valid", 32'(ir_valid), 32'h0);
        chk("async_rst_ir", 32'(ir), 32'h0);
        chk("async_rst_req", 32'(mem_req), 32'h1);
        step();
        rst_n = 1'b1;
      end else begin
        step();
      end
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
